// File: rtl/inst_fetch.sv
// RV32I instruction-fetch stage: assembles a little-endian word from a byte-wide memory
// port and loads the IF/ID register. Define ICACHE_EN to add a direct-mapped one-word-line cache.
module inst_fetch #(
  parameter int ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ex_b_flag_i,
  input  logic        stall_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_byte_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        stall_req_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

  state_t      state, state_nx;
  logic [2:0]  issue_cnt, issue_nx, recv_cnt;
  logic [31:0] fpc, word_buf, fetch_word, out_pc, out_word, hit_word;
  logic        rx_vld, done, deliver, hit, hit_park;

  // rx_vld marks that mem_byte_i carries a byte of the current fetch
  assign done       = (state == FETCH) && rx_vld && (recv_cnt == 3'd3);
  assign fetch_word = {mem_byte_i, word_buf[23:0]};

  always_comb begin
    state_nx    = state;
    issue_nx    = issue_cnt;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    stall_req_o = 1'b0;
    deliver     = 1'b0;
    hit_park    = 1'b0;
    out_pc      = fpc;
    out_word    = word_buf;
    if (!rst) begin
      if (ex_b_flag_i) begin
        state_nx = IDLE;
        issue_nx = '0;
      end else begin
        case (state)
          IDLE: begin
            if (hit) begin
              out_pc   = pc_i;
              out_word = hit_word;
              if (stall_i) begin
                stall_req_o = 1'b1;
                hit_park    = 1'b1;
                state_nx    = WAIT;
              end else begin
                deliver = 1'b1;
              end
            end else begin
              stall_req_o = 1'b1;
              state_nx    = FETCH;
              issue_nx    = '0;
              if (mem_grant_i) begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc_i;
                issue_nx   = 3'd1;
              end
            end
          end
          FETCH: begin
            if (mem_grant_i && (issue_cnt < 3'd4)) begin
              mem_req_o  = 1'b1;
              mem_addr_o = fpc + {29'b0, issue_cnt};
              issue_nx   = issue_cnt + 3'd1;
            end
            if (done && !stall_i) begin
              deliver  = 1'b1;
              out_word = fetch_word;
              state_nx = IDLE;
            end else begin
              stall_req_o = 1'b1;
              if (done) state_nx = WAIT;
            end
          end
          WAIT: begin
            if (!stall_i) begin
              deliver  = 1'b1;
              state_nx = IDLE;
            end else begin
              stall_req_o = 1'b1;
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      rx_vld     <= 1'b0;
      fpc        <= '0;
      word_buf   <= '0;
      if_pc_o    <= '0;
      if_inst_o  <= NOP;
      if_valid_o <= 1'b0;
    end else begin
      state     <= state_nx;
      issue_cnt <= issue_nx;
      rx_vld    <= mem_req_o;
      if (state == IDLE) fpc <= pc_i;
      if (ex_b_flag_i || done || (state != FETCH)) recv_cnt <= '0;
      else if (rx_vld)                            recv_cnt <= recv_cnt + 3'd1;
      if (hit_park)
        word_buf <= hit_word;
      else if (rx_vld && (state == FETCH) && !ex_b_flag_i)
        word_buf[{recv_cnt[1:0], 3'b000} +: 8] <= mem_byte_i;
      // a flush bubbles IF/ID even under a downstream hold
      if (ex_b_flag_i) begin
        if_valid_o <= 1'b0;
        if_inst_o  <= NOP;
      end else if (!stall_i) begin
        if (deliver) begin
          if_pc_o    <= out_pc;
          if_inst_o  <= out_word;
          if_valid_o <= 1'b1;
        end else begin
          if_inst_o  <= NOP;
          if_valid_o <= 1'b0;
        end
      end
    end
  end

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ICACHE_LINES-1:0] c_vld;
  logic [TAG_W-1:0]        c_tag  [ICACHE_LINES];
  logic [31:0]             c_word [ICACHE_LINES];
  logic [IDX_W-1:0]        rd_idx, wr_idx;
  logic                    fill;

  assign rd_idx   = pc_i[IDX_W+1:2];
  assign wr_idx   = fpc[IDX_W+1:2];
  assign hit      = (state == IDLE) && c_vld[rd_idx] && (c_tag[rd_idx] == pc_i[31:IDX_W+2]);
  assign hit_word = c_word[rd_idx];
  assign fill     = done && !ex_b_flag_i;

  always_ff @(posedge clk) begin
    if (rst)       c_vld         <= '0;
    else if (fill) c_vld[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      c_tag[wr_idx]  <= fpc[31:IDX_W+2];
      c_word[wr_idx] <= fetch_word;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized/directed bench for inst_fetch; expectations come from a byte-memory model
// and latency rules (4th granted cycle + 1), optional cache behaviour keyed on ICACHE_EN.
module tb_inst_fetch;
  localparam int LINES = 16;

  logic        clk, rst, ex_b_flag_i, stall_i, mem_grant_i;
  logic [31:0] pc_i;
  logic [7:0]  mem_byte_i;
  logic        mem_req_o, stall_req_o, if_valid_o;
  logic [31:0] mem_addr_o, if_pc_o, if_inst_o;

  inst_fetch #(.ICACHE_LINES(LINES)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ex_b_flag_i(ex_b_flag_i), .stall_i(stall_i),
    .mem_grant_i(mem_grant_i), .mem_byte_i(mem_byte_i), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .stall_req_o(stall_req_o), .if_pc_o(if_pc_o),
    .if_inst_o(if_inst_o), .if_valid_o(if_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ICACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        s_req, s_stall;
  logic [31:0] s_addr;
  logic        rq [32];
  logic        sr [32];
  logic        vv [32];
  logic [31:0] ad [32];
  logic [31:0] ii [32];
  logic [31:0] pp [32];

  function automatic logic [7:0] mem_fn(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return {mem_fn(pc + 32'd3), mem_fn(pc + 32'd2), mem_fn(pc + 32'd1), mem_fn(pc)};
  endfunction

  // one clock: sample combinational outputs mid-cycle, then answer the byte read after the edge
  task automatic cycle();
    @(negedge clk);
    s_req   = mem_req_o;
    s_addr  = mem_addr_o;
    s_stall = stall_req_o;
    @(posedge clk);
    #1;
    mem_byte_i = s_req ? mem_fn(s_addr) : 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; ex_b_flag_i = 1'b0; stall_i = 1'b0; mem_grant_i = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // runs one fetch until stall_req_o drops (delivery or flush); dc = that cycle or -1
  task automatic drive_fetch(input logic [31:0] pc, input logic [31:0] gm, input logic [31:0] sm,
                             input logic [31:0] fm, output int dc);
    dc = -1;
    for (int c = 1; c < 32; c++) begin
      pc_i = pc; mem_grant_i = gm[c]; stall_i = sm[c]; ex_b_flag_i = fm[c];
      cycle();
      rq[c] = s_req; ad[c] = s_addr; sr[c] = s_stall;
      vv[c] = if_valid_o; ii[c] = if_inst_o; pp[c] = if_pc_o;
      if (s_stall === 1'b0) begin
        dc = c;
        break;
      end
    end
    ex_b_flag_i = 1'b0; stall_i = 1'b0; mem_grant_i = 1'b1;
  endtask

  task automatic test_reset();
    pc_i = 32'h0; mem_byte_i = 8'h0;
    do_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if ({mem_req_o, mem_addr_o, stall_req_o} !== 34'h0) begin n_err++;
      $display("FAIL reset_comb: req=%b addr=%h stall_req=%b, want 0", mem_req_o, mem_addr_o, stall_req_o); end
    n_cmp++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b0, 32'h0, 32'h13}) begin n_err++;
      $display("FAIL reset_ifid: valid=%b pc=%h inst=%h, want 0/0/00000013", if_valid_o, if_pc_o, if_inst_o); end
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int dc;
    logic ok;
    do_reset();
    drive_fetch(32'h0, '1, '0, '0, dc);
    ok = 1'b1;
    for (int c = 1; c <= 4; c++)
      if (rq[c] !== 1'b1 || ad[c] !== 32'(c - 1) || sr[c] !== 1'b1 || vv[c] !== 1'b0) ok = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_err++;
      $display("FAIL basic_issue: addr %h %h %h %h, want 0 1 2 3 with stall_req high", ad[1], ad[2], ad[3], ad[4]); end
    n_cmp++; if (dc !== 5) begin n_err++; $display("FAIL basic_latency: %0d want 5", dc); end
    n_cmp++; if ({vv[5], pp[5], ii[5]} !== {1'b1, 32'h0, 32'h0010_0513}) begin n_err++;
      $display("FAIL basic_ifid: valid=%b pc=%h inst=%h, want 1/0/00100513", vv[5], pp[5], ii[5]); end
  endtask

  task automatic test_grant_gap();
    int dc;
    do_reset();
    drive_fetch(32'h0, ~32'h4, '0, '0, dc);
    n_cmp++; if ({rq[2], rq[3], ad[3]} !== {1'b0, 1'b1, 32'h1}) begin n_err++;
      $display("FAIL gap_issue: c2 req=%b c3 req=%b addr=%h, want 0/1/1", rq[2], rq[3], ad[3]); end
    n_cmp++; if (dc !== 6 || ii[6] !== 32'h0010_0513) begin n_err++;
      $display("FAIL gap_delivery: cycle %0d inst %h, want 6 / 00100513", dc, ii[6]); end
  endtask

  task automatic test_flush();
    int dc;
    do_reset();
    drive_fetch(32'h40, '1, '0, 32'h8, dc);
    n_cmp++; if (dc !== 3) begin n_err++; $display("FAIL flush_stall_req: dropped at %0d want 3", dc); end
    n_cmp++; if ({vv[3], ii[3]} !== {1'b0, 32'h13}) begin n_err++;
      $display("FAIL flush_bubble: valid=%b inst=%h, want 0/00000013", vv[3], ii[3]); end
    drive_fetch(32'h80, '1, '0, '0, dc);
    n_cmp++; if (ad[1] !== 32'h80 || dc !== 5 || {vv[5], pp[5], ii[5]} !== {1'b1, 32'h80, exp_inst(32'h80)}) begin
      n_err++; $display("FAIL flush_refetch: addr1=%h cycle=%0d inst=%h pc=%h, want 80/5/%h/80",
                        ad[1], dc, ii[5], pp[5], exp_inst(32'h80)); end
  endtask

  task automatic test_stall();
    int dc;
    logic ok;
    do_reset();
    drive_fetch(32'h0C, '1, 32'h0000_01F0, '0, dc);
    ok = 1'b1;
    for (int c = 5; c <= 8; c++) if (sr[c] !== 1'b1 || rq[c] !== 1'b0) ok = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL stall_wait: stall_req %b%b%b%b, want 1111", sr[5], sr[6], sr[7], sr[8]); end
    n_cmp++; if ({vv[8], ii[8]} !== {1'b0, 32'h13}) begin n_err++;
      $display("FAIL stall_hold: valid=%b inst=%h, want 0/00000013", vv[8], ii[8]); end
    n_cmp++; if (dc !== 9 || {vv[9], pp[9], ii[9]} !== {1'b1, 32'h0C, exp_inst(32'h0C)}) begin n_err++;
      $display("FAIL stall_delivery: cycle=%0d inst=%h pc=%h, want 9/%h/0c", dc, ii[9], pp[9], exp_inst(32'h0C)); end
  endtask

  task automatic test_random();
    int dc, k, g3;
    logic ok;
    logic [31:0] pc, gm;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pc = (i == 7) ? 32'hFFFF_FFFC : {8'(i), 22'($urandom), 2'b00};
      gm = '0;
      for (int c = 1; c < 32; c++) gm[c] = ($urandom_range(0, 3) != 0);
      gm[31:20] = '1;
      k = 0; g3 = 0;
      for (int c = 1; c < 32 && k < 4; c++) if (gm[c]) begin k++; g3 = c; end
      drive_fetch(pc, gm, '0, '0, dc);
      n_cmp++; if (dc !== g3 + 1) begin n_err++;
        $display("FAIL rand_latency[%0d]: cycle %0d want %0d", i, dc, g3 + 1); end
      if (dc == g3 + 1) begin
        ok = 1'b1; k = 0;
        for (int c = 1; c <= g3; c++) begin
          if (gm[c]) begin
            if (rq[c] !== 1'b1 || ad[c] !== pc + 32'(k)) ok = 1'b0;
            k++;
          end else if (rq[c] !== 1'b0) ok = 1'b0;
        end
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rand_addr[%0d]: issue order wrong for pc %h", i, pc); end
        n_cmp++; if ({vv[dc], pp[dc], ii[dc]} !== {1'b1, pc, exp_inst(pc)}) begin n_err++;
          $display("FAIL rand_ifid[%0d]: valid=%b pc=%h inst=%h, want 1/%h/%h", i, vv[dc], pp[dc], ii[dc], pc, exp_inst(pc)); end
      end
    end
  endtask

  task automatic test_cache();
    int dc;
    logic [31:0] far;
    far = 32'h100 + 32'(4 * LINES);
    do_reset();
    drive_fetch(32'h100, '1, '0, '0, dc);
    n_cmp++; if (dc !== 5) begin n_err++; $display("FAIL cache_first_miss: %0d want 5", dc); end
    drive_fetch(32'h104, '1, '0, '0, dc);
    drive_fetch(32'h100, '1, '0, '0, dc);
    n_cmp++; if (dc !== (CACHE ? 1 : 5) || rq[1] !== !CACHE) begin n_err++;
      $display("FAIL cache_refetch: cycle=%0d req1=%b, want %0d/%b", dc, rq[1], CACHE ? 1 : 5, !CACHE); end
    n_cmp++; if (dc > 0 && {vv[dc], pp[dc], ii[dc]} !== {1'b1, 32'h100, exp_inst(32'h100)}) begin n_err++;
      $display("FAIL cache_refetch_ifid: valid=%b pc=%h inst=%h", vv[dc], pp[dc], ii[dc]); end
    drive_fetch(32'h104, '1, 32'h6, '0, dc);
    n_cmp++; if (dc !== (CACHE ? 3 : 5) || ii[dc] !== exp_inst(32'h104) || pp[dc] !== 32'h104) begin n_err++;
      $display("FAIL cache_hit_stall: cycle=%0d inst=%h pc=%h", dc, ii[dc], pp[dc]); end
    drive_fetch(32'h104, '1, '0, 32'h2, dc);
    drive_fetch(32'h104, '1, '0, '0, dc);
    n_cmp++; if (dc !== (CACHE ? 1 : 5)) begin n_err++; $display("FAIL cache_after_flush: %0d want %0d", dc, CACHE ? 1 : 5); end
    drive_fetch(far, '1, '0, '0, dc);
    drive_fetch(32'h100, '1, '0, '0, dc);
    n_cmp++; if (dc !== 5 || ii[5] !== exp_inst(32'h100)) begin n_err++;
      $display("FAIL cache_evict: cycle=%0d inst=%h, want 5/%h", dc, ii[5], exp_inst(32'h100)); end
  endtask

  task automatic test_reset_mid();
    int dc;
    pc_i = 32'h200; mem_grant_i = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    #1;
    n_cmp++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b0, 32'h0, 32'h13}) begin n_err++;
      $display("FAIL midreset_ifid: valid=%b pc=%h inst=%h, want 0/0/00000013", if_valid_o, if_pc_o, if_inst_o); end
    n_cmp++; if ({mem_req_o, mem_addr_o, stall_req_o} !== 34'h0) begin n_err++;
      $display("FAIL midreset_comb: req=%b addr=%h stall_req=%b", mem_req_o, mem_addr_o, stall_req_o); end
    rst = 1'b0;
    drive_fetch(32'h100, '1, '0, '0, dc);
    n_cmp++; if (dc !== 5 || ii[5] !== exp_inst(32'h100)) begin n_err++;
      $display("FAIL midreset_refetch: cycle=%0d inst=%h, want 5/%h", dc, ii[5], exp_inst(32'h100)); end
  endtask

  initial begin
    rst = 1'b1; pc_i = '0; ex_b_flag_i = 1'b0; stall_i = 1'b0; mem_grant_i = 1'b0; mem_byte_i = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_grant_gap();
    test_flush();
    test_stall();
    test_random();
    test_cache();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish within 500000 time units");
    $fatal(1, "timeout");
  end
endmodule
